// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the datapath and a word-wide data memory.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module mem_access_ctrl #(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_ren,
    output logic        mem_wen,
    input  logic [31:0] mem_data
);

    typedef enum logic [2:0] {StIdle, StRead, StCapt, StWrite, StDone} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mem_ren_q, mem_ren_d;
    logic        mem_wen_q, mem_wen_d;

    logic        req_err;
    logic [4:0]  lane_sh;
    logic [15:0] lane_data;
    logic [31:0] lane_mask;
    logic [31:0] merged;
    logic [31:0] load_val;

    assign req_err = (size == 2'b11)
                  || (size == 2'b01 && addr[0])
                  || (size == 2'b10 && addr[1:0] != 2'b00)
                  || (addr >= MEM_BYTES);

    // Store data sits right-justified in mem_wdata_q until CAPT shifts it into its lane(s).
    always_comb begin
        lane_sh   = (size_q == 2'b00) ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
        lane_data = 16'(mem_data >> lane_sh);
        lane_mask = ((size_q == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff) << lane_sh;
        merged    = (mem_data & ~lane_mask) | ((mem_wdata_q << lane_sh) & lane_mask);
        case (size_q)
            2'b00:   load_val = {{24{sign_q & lane_data[7]}}, lane_data[7:0]};
            2'b01:   load_val = {{16{sign_q & lane_data[15]}}, lane_data};
            default: load_val = mem_data;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        sign_d      = sign_q;
        addr_d      = addr_q;
        rdata_d     = rdata_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_ren_d   = 1'b0;
        mem_wen_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    we_d   = we;
                    size_d = size;
                    sign_d = sign_ext;
                    addr_d = addr;
                    if (req_err) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        if (we) mem_wdata_d = wdata;
                        if (we && size == 2'b10) begin
                            state_d   = StWrite;
                            mem_wen_d = 1'b1;
                        end else begin
                            state_d   = StRead;
                            mem_ren_d = 1'b1;
                        end
                    end
                end
            end
            StRead: state_d = StCapt;
            StCapt: begin
                if (we_q) begin
                    mem_wdata_d = merged;
                    state_d     = StWrite;
                    mem_wen_d   = 1'b1;
                end else begin
                    rdata_d = load_val;
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            StWrite: begin
                state_d = StDone;
                done_d  = 1'b1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            sign_q      <= 1'b0;
            addr_q      <= 32'h0;
            rdata_q     <= 32'h0;
            mem_wdata_q <= 32'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            addr_q      <= addr_d;
            rdata_q     <= rdata_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
        end
    end

    assign rdata     = rdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != StIdle);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = mem_wdata_q;
    assign mem_ren   = mem_ren_q;
    assign mem_wen   = mem_wen_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: byte-array reference model feeds expectations,
// a negedge monitor checks every done pulse and the memory traffic of its transaction.
module tb_mem_access_ctrl;

    localparam int unsigned MB = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_data;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_BYTES(MB)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ren  (mem_ren),
        .mem_wen  (mem_wen),
        .mem_data (mem_data)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'h5a3c_96e1 ^ (32'(i) * 32'h0103_0507);
    endfunction

    // Synchronous word memory: read data appears the cycle after mem_ren is sampled.
    logic [31:0] env_mem [MB/4];
    logic        env_init;
    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < MB / 4; i++) env_mem[i] <= init_word(i);
        end else if (mem_wen) begin
            env_mem[mem_addr[5:2]] <= mem_wdata;
        end
        if (mem_ren) mem_data <= env_mem[mem_addr[5:2]];
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          ren;
        int          wen;
        logic [31:0] maddr;
        logic [31:0] wword;
        int          t0;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  ref_mem [MB];
    logic [31:0] ref_rdata;
    int          total  = 0;
    int          passed = 0;
    int          ncyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor
    int          ren_cnt, wen_cnt;
    logic [31:0] ren_addr, w_addr, w_data;
    bit          both_seen;
    always @(negedge clk) begin
        exp_t e;
        ncyc = ncyc + 1;
        if (reset !== 1'b1) begin
            ren_cnt = 0; wen_cnt = 0; both_seen = 0;
        end else begin
            if (mem_ren) begin ren_cnt++; ren_addr = mem_addr; end
            if (mem_wen) begin wen_cnt++; w_addr = mem_addr; w_data = mem_wdata; end
            if (mem_ren && mem_wen) both_seen = 1;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_done: got done=1 expected no pending request");
                end else begin
                    e = sb.pop_front();
                    chk("err", 32'(err), 32'(e.err));
                    chk("rdata", rdata, e.rdata);
                    chk("latency", 32'(ncyc - e.t0), 32'(e.lat));
                    chk("ren_count", 32'(ren_cnt), 32'(e.ren));
                    chk("wen_count", 32'(wen_cnt), 32'(e.wen));
                    chk("ren_wen_overlap", 32'(both_seen), 32'd0);
                    if (e.ren > 0) chk("read_addr", ren_addr, e.maddr);
                    if (e.wen > 0) begin
                        chk("write_addr", w_addr, e.maddr);
                        chk("write_data", w_data, e.wword);
                    end
                end
                ren_cnt = 0; wen_cnt = 0; both_seen = 0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (n == 20) begin
            total++;
            $display("FAIL idle_timeout: got busy=%0b expected 0 within 20 cycles", busy);
        end
    endtask

    task automatic issue(input bit i_we, input logic [1:0] i_size, input bit i_sign,
                         input logic [31:0] i_addr, input logic [31:0] i_wdata, input bit junk);
        exp_t        e;
        int          nb, a, base;
        logic [31:0] v;
        wait_idle();
        req = 1'b1; we = i_we; size = i_size; sign_ext = i_sign; addr = i_addr; wdata = i_wdata;
        nb       = 1 << i_size;
        e.t0     = ncyc;
        e.maddr  = {i_addr[31:2], 2'b00};
        e.wword  = 32'h0;
        e.err    = (i_size == 2'b11) || ((i_addr % nb) != 0) || (i_addr >= MB);
        if (e.err) begin
            e.lat = 1; e.ren = 0; e.wen = 0;
        end else begin
            a = int'(i_addr[5:0]);
            if (!i_we) begin
                v = 32'h0;
                for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
                if (i_sign && nb < 4 && v[8 * nb - 1]) v = v | (32'hffff_ffff << (8 * nb));
                ref_rdata = v;
                e.lat = 3; e.ren = 1; e.wen = 0;
            end else begin
                for (int i = 0; i < nb; i++) ref_mem[a + i] = 8'(i_wdata >> (8 * i));
                base    = a & ~3;
                e.wword = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
                e.lat   = (nb == 4) ? 2 : 4;
                e.ren   = (nb == 4) ? 0 : 1;
                e.wen   = 1;
            end
        end
        e.rdata = ref_rdata;
        sb.push_back(e);
        @(negedge clk); #1;
        if (junk) begin
            // Request while busy must be ignored entirely.
            req = 1'b1; we = 1'($urandom); size = 2'($urandom); addr = $urandom_range(0, 63);
            wdata = $urandom;
            @(negedge clk); #1;
        end
        req = 1'b0;
    endtask

    initial begin
        int n;
        for (int w = 0; w < MB / 4; w++)
            for (int b = 0; b < 4; b++) ref_mem[4 * w + b] = 8'(init_word(w) >> (8 * b));
        ref_rdata = 32'h0;
        reset = 1'b0; env_init = 1'b1;
        req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_ren", 32'(mem_ren), 32'd0);
        chk("reset_mem_wen", 32'(mem_wen), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        #1 reset = 1'b1; env_init = 1'b0;

        issue(1, 2'b10, 0, 32'h10, 32'h8899_aabb, 0);
        issue(0, 2'b10, 0, 32'h10, 32'h0, 0);
        issue(0, 2'b00, 1, 32'h11, 32'h0, 0);
        issue(0, 2'b00, 0, 32'h11, 32'h0, 0);
        issue(0, 2'b01, 1, 32'h12, 32'h0, 0);
        issue(0, 2'b01, 0, 32'h12, 32'h0, 0);
        issue(1, 2'b00, 0, 32'h13, 32'h1234_565c, 0);
        issue(0, 2'b10, 0, 32'h10, 32'h0, 0);
        issue(0, 2'b01, 0, 32'h11, 32'h0, 0);
        issue(1, 2'b10, 0, 32'h12, 32'hdead_beef, 0);
        issue(0, 2'b11, 0, 32'h10, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h40, 32'h0, 0);
        issue(0, 2'b00, 1, 32'h1f, 32'h0, 1);
        issue(0, 2'b10, 0, 32'h3c, 32'h0, 0);

        // Abort a byte store while it sits in CAPT.
        wait_idle();
        req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h10; wdata = $urandom;
        @(negedge clk); #1 req = 1'b0;
        @(negedge clk);
        chk("abort_capt_busy", 32'(busy), 32'd1);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_mem_wen", 32'(mem_wen), 32'd0);
        chk("abort_rdata", rdata, 32'h0);
        #1 reset = 1'b1;
        ref_rdata = 32'h0;
        issue(0, 2'b10, 0, 32'h10, 32'h0, 0);

        for (int k = 0; k < 150; k++) begin
            logic [1:0]  s;
            logic [31:0] a;
            s = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
            issue(1'($urandom), s, 1'($urandom), a, $urandom, $urandom_range(0, 3) == 0);
        end

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
